rd_stream_fetch: RTL and testbench
==================================

RD_STREAM_FETCH -- requirements
Module: rd_stream_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, line buffer depth (power of 2, >=2); also maximum outstanding memory reads.
REQ-002 SHALL have parameter LINE_BYTES, default 64, byte stride between consecutive 512-bit lines.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset; all state SHALL clear while rst is low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a transfer when idle.
REQ-007 base_addr  input  64  byte address of the first line, sampled on accepted start.
REQ-008 num_lines  input  64  number of 512-bit lines to fetch, sampled on accepted start.
REQ-009 mem_rd_req  output  1  memory read request valid.
REQ-010 mem_rd_addr  output  64  byte address of the requested line.
REQ-011 mem_rd_ready  input  1  memory accepts the request when mem_rd_req & mem_rd_ready.
REQ-012 mem_rd_valid  input  1  in-order read response valid, one line per cycle.
REQ-013 mem_rd_data  input  512  response line.
REQ-014 available_read  output  1  at least one line is buffered for the PE-side consumer.
REQ-015 data_in  output  512  head line of the buffer (show-ahead).
REQ-016 req_rd_data  input  1  consumer pop; effective only when available_read=1.
REQ-017 done  output  1  all num_lines lines delivered to the consumer.
REQ-018 err  output  1  sticky: response received with no request outstanding.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-020 IDLE: start=1 SHALL latch base_addr/num_lines, clear counters, go FETCH, or go DONE directly when num_lines=0.
REQ-021 start SHALL be ignored in FETCH and DRAIN; in DONE, start SHALL behave as in IDLE (new transfer, done deasserts next cycle).
REQ-022 FETCH: mem_rd_req SHALL be 1 iff issued<num_lines and (outstanding + fifo_count) < FIFO_DEPTH; credit check prevents buffer overflow.
REQ-023 mem_rd_addr SHALL equal base_addr + issued*LINE_BYTES, modulo 2^64 (wraps, no error).
REQ-024 mem_rd_req and mem_rd_addr SHALL be registered and held stable until accepted; issued increments on each acceptance.
REQ-025 First request SHALL assert the cycle after the accepted start.
REQ-026 FETCH -> DRAIN SHALL occur on acceptance of the last request; DRAIN -> DONE when delivered = num_lines.
REQ-027 mem_rd_valid with outstanding>0 SHALL push mem_rd_data into the buffer and decrement outstanding; acceptance and response in the same cycle SHALL leave outstanding unchanged.
REQ-028 mem_rd_valid with outstanding=0 SHALL be dropped and SHALL set err until reset.
REQ-029 available_read SHALL be 1 iff fifo_count>0; a pushed line SHALL be visible on data_in and available_read the cycle after mem_rd_valid.
REQ-030 req_rd_data & available_read SHALL pop the head and increment delivered; req_rd_data while empty SHALL have no effect.
REQ-031 Simultaneous push and pop SHALL be supported at any occupancy, including full and one-entry; fifo_count unchanged.
REQ-032 Sustained throughput SHALL be one line per cycle when memory and consumer are always ready.
REQ-033 done SHALL be 1 only in DONE and held until the next accepted start or reset.

Reset
REQ-034 While rst=0: state IDLE, mem_rd_req=0, mem_rd_addr=0, available_read=0, data_in=0, done=0, err=0, all counters and buffer pointers 0.
REQ-035 Reset mid-transfer SHALL abort; responses for pre-reset requests arriving afterwards SHALL be handled per REQ-028.

Verification
REQ-036 base_addr=0x1000, num_lines=3, memory/consumer always ready, 1-cycle memory latency -> addresses 0x1000,0x1040,0x1080; lines delivered in order; done=1 after third pop.
REQ-037 num_lines=10, req_rd_data held 0 -> exactly 4 requests issued, mem_rd_req drops, available_read=1; releasing consumer -> all 10 lines delivered in order, never more than 4 buffered.
REQ-038 num_lines=0 start -> done=1 the following cycle, no mem_rd_req ever asserted.
REQ-039 mem_rd_ready toggled randomly -> mem_rd_addr stable while mem_rd_req=1 and unaccepted; no skipped or duplicated address.
REQ-040 base_addr=0xFFFF_FFFF_FFFF_FFC0, num_lines=2 -> addresses 0xFFFF_FFFF_FFFF_FFC0 then 0x0; err stays 0.
REQ-041 rst low after 2 requests accepted, then 2 stray mem_rd_valid -> outputs at reset values, stray data dropped, err=1; new start completes normally.

Source files
------------

// File: rtl/rd_stream_fetch.sv
// Streaming line fetcher: issues credit-limited reads of consecutive 512-bit lines
// and buffers in-order responses in a show-ahead FIFO for a PE-side consumer.
module rd_stream_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_BYTES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  base_addr,
    input  logic [63:0]  num_lines,
    output logic         mem_rd_req,
    output logic [63:0]  mem_rd_addr,
    input  logic         mem_rd_ready,
    input  logic         mem_rd_valid,
    input  logic [511:0] mem_rd_data,
    output logic         available_read,
    output logic [511:0] data_in,
    input  logic         req_rd_data,
    output logic         done,
    output logic         err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];
    localparam logic [63:0]    STRIDE  = 64'(LINE_BYTES);

    logic [1:0]       r_state;
    logic [63:0]      r_num;
    logic [63:0]      r_issued;
    logic [63:0]      r_delivered;
    logic [CNT_W-1:0] r_out;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_req;
    logic [63:0]      r_addr;
    logic             r_err;
    logic [511:0]     r_buf [FIFO_DEPTH];

    logic             w_start_ok;
    logic             w_acc;
    logic             w_resp;
    logic             w_stray;
    logic             w_pop;
    logic [63:0]      w_issued_nx;
    logic [63:0]      w_delivered_nx;
    logic [CNT_W-1:0] w_out_nx;
    logic [CNT_W-1:0] w_count_nx;
    logic             w_credit;
    logic [1:0]       w_state_nx;
    logic             w_req_nx;

    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_acc      = r_req & mem_rd_ready;
    assign w_resp     = mem_rd_valid & (r_out != '0);
    assign w_stray    = mem_rd_valid & (r_out == '0);
    assign w_pop      = req_rd_data & (r_count != '0);

    assign w_issued_nx    = r_issued + {63'd0, w_acc};
    assign w_delivered_nx = r_delivered + {63'd0, w_pop};
    assign w_out_nx       = r_out + {{(CNT_W-1){1'b0}}, w_acc} - {{(CNT_W-1){1'b0}}, w_resp};
    assign w_count_nx     = r_count + {{(CNT_W-1){1'b0}}, w_resp} - {{(CNT_W-1){1'b0}}, w_pop};

    // In-flight reads plus buffered lines must never exceed buffer capacity.
    assign w_credit = ({1'b0, w_out_nx} + {1'b0, w_count_nx}) < DEPTH_C;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nx = (num_lines == 64'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (w_acc && (w_issued_nx == r_num)) w_state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_delivered_nx == r_num) w_state_nx = S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Request is registered; an unaccepted request stays up because the credit sum cannot grow.
    always_comb begin
        w_req_nx = 1'b0;
        if (w_start_ok) begin
            w_req_nx = (num_lines != 64'd0);
        end else if ((r_state == S_FETCH) && (w_state_nx == S_FETCH)) begin
            w_req_nx = (w_issued_nx < r_num) && w_credit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_out       <= '0;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            if (w_stray) r_err <= 1'b1;
            if (w_start_ok) begin
                r_num       <= num_lines;
                r_addr      <= base_addr;
                r_issued    <= '0;
                r_delivered <= '0;
                r_out       <= '0;
                r_count     <= '0;
                r_wptr      <= '0;
                r_rptr      <= '0;
            end else begin
                r_issued    <= w_issued_nx;
                r_delivered <= w_delivered_nx;
                r_out       <= w_out_nx;
                r_count     <= w_count_nx;
                if (w_acc)  r_addr <= r_addr + STRIDE;
                if (w_resp) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Line storage carries no reset; data_in is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_resp) r_buf[r_wptr] <= mem_rd_data;
    end

    assign mem_rd_req     = r_req;
    assign mem_rd_addr    = r_addr;
    assign available_read = (r_count != '0);
    assign data_in        = (r_count != '0) ? r_buf[r_rptr] : '0;
    assign done           = (r_state == S_DONE);
    assign err            = r_err;

endmodule

// File: tb/tb_rd_stream_fetch.sv
// Scoreboard bench for rd_stream_fetch: memory model with 1-cycle latency,
// expected lines queued on request acceptance and compared on consumer pops.
module tb_rd_stream_fetch;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  base_addr = '0;
    logic [63:0]  num_lines = '0;
    logic         mem_rd_req;
    logic [63:0]  mem_rd_addr;
    logic         mem_rd_ready = 1'b0;
    logic         mem_rd_valid = 1'b0;
    logic [511:0] mem_rd_data = '0;
    logic         available_read;
    logic [511:0] data_in;
    logic         req_rd_data = 1'b0;
    logic         done;
    logic         err;

    rd_stream_fetch #(.FIFO_DEPTH(4), .LINE_BYTES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .available_read(available_read), .data_in(data_in), .req_rd_data(req_rd_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [511:0] exp_q [$];
    logic [63:0]  pend_q [$];
    logic [63:0]  exp_addr = '0;
    logic [63:0]  last_addr = '0;
    logic [63:0]  prev_addr = '0;
    int n_acc = 0, n_pop = 0, n_req = 0, max_buf = 0, stray_n = 0, cons_mode = 0;
    bit rnd_ready = 1'b0;
    bit prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = a + 64'(i) * 64'h0001_1111_0000_1111;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic new_test();
        n_acc = 0; n_pop = 0; n_req = 0; max_buf = 0;
    endtask

    task automatic start_xfer(input logic [63:0] b, input logic [63:0] n);
        tick();
        base_addr = b;
        num_lines = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && !done; i++) tick();
        chk("done_wait", done, 1'b1);
    endtask

    // Memory and consumer model, acting mid-cycle on values the next rising edge will see.
    always @(negedge clk) begin
        if (!rst) begin
            mem_rd_valid = 1'b0;
            mem_rd_ready = 1'b0;
            req_rd_data  = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (mem_rd_req) n_req++;
            if (prev_stall) begin
                chk("addr_hold", mem_rd_addr, prev_addr);
                chk("req_hold", mem_rd_req, 1'b1);
            end
            mem_rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stray_n > 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = {8{64'hDEAD_BEEF_0BAD_F00D}};
                stray_n--;
            end else if (pend_q.size() > 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = line_of(pend_q.pop_front());
            end else begin
                mem_rd_valid = 1'b0;
            end
            if (mem_rd_req && mem_rd_ready) begin
                chk("rd_addr", mem_rd_addr, exp_addr);
                exp_addr  = exp_addr + 64'd64;
                last_addr = mem_rd_addr;
                pend_q.push_back(mem_rd_addr);
                exp_q.push_back(line_of(mem_rd_addr));
                n_acc++;
            end
            prev_stall = mem_rd_req && !mem_rd_ready;
            prev_addr  = mem_rd_addr;
            req_rd_data = (cons_mode == 0) ? 1'b0 :
                          (cons_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (req_rd_data && available_read) begin
                if (exp_q.size() == 0) chk("pop_underflow", 1'b1, 1'b0);
                else chk("line_data", data_in, exp_q.pop_front());
                n_pop++;
            end
            if (n_acc - n_pop > max_buf) max_buf = n_acc - n_pop;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_req", mem_rd_req, 1'b0);
        chk("rst_addr", mem_rd_addr, 64'd0);
        chk("rst_avail", available_read, 1'b0);
        chk("rst_data", data_in, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;
        tick();

        // Three lines, everything ready: back-to-back issue and delivery
        new_test(); rnd_ready = 1'b0; cons_mode = 1; exp_addr = 64'h1000;
        start_xfer(64'h1000, 64'd3);
        chk("A_first_req", mem_rd_req, 1'b1);
        chk("A_first_addr", mem_rd_addr, 64'h1000);
        repeat (4) tick();
        chk("A_done_early", done, 1'b0);
        tick();
        chk("A_done", done, 1'b1);
        chk("A_pops", n_pop, 3);
        chk("A_err", err, 1'b0);

        // Stalled consumer: credit limit caps issue at the buffer depth
        new_test(); cons_mode = 0; exp_addr = 64'h2000;
        start_xfer(64'h2000, 64'd10);
        repeat (20) tick();
        chk("B_issued", n_acc, 4);
        chk("B_req_low", mem_rd_req, 1'b0);
        chk("B_avail", available_read, 1'b1);
        chk("B_head", data_in, line_of(64'h2000));
        cons_mode = 1;
        wait_done(200);
        chk("B_pops", n_pop, 10);
        chk("B_maxbuf", max_buf, 4);

        // Zero-length transfer started from DONE
        new_test();
        start_xfer(64'h0, 64'd0);
        chk("C_done", done, 1'b1);
        repeat (3) tick();
        chk("C_no_req", n_req, 0);
        chk("C_done_hold", done, 1'b1);

        // Random memory back-pressure and random consumer
        new_test(); rnd_ready = 1'b1; cons_mode = 2; exp_addr = 64'h40000;
        start_xfer(64'h40000, 64'd12);
        chk("D_done_clr", done, 1'b0);
        wait_done(600);
        chk("D_acc", n_acc, 12);
        chk("D_pops", n_pop, 12);

        // Address wrap past 2^64
        new_test(); rnd_ready = 1'b0; cons_mode = 1; exp_addr = 64'hFFFF_FFFF_FFFF_FFC0;
        start_xfer(64'hFFFF_FFFF_FFFF_FFC0, 64'd2);
        wait_done(100);
        chk("E_last_addr", last_addr, 64'd0);
        chk("E_pops", n_pop, 2);
        chk("E_err", err, 1'b0);

        // Reset mid-transfer, then stray responses, then a fresh transfer
        new_test(); cons_mode = 0; exp_addr = 64'h3000;
        start_xfer(64'h3000, 64'd8);
        for (int i = 0; i < 20 && n_acc < 2; i++) tick();
        chk("F_acc", n_acc, 2);
        rst = 1'b0;
        #1;
        chk("F_rst_req", mem_rd_req, 1'b0);
        chk("F_rst_addr", mem_rd_addr, 64'd0);
        chk("F_rst_avail", available_read, 1'b0);
        chk("F_rst_data", data_in, '0);
        chk("F_rst_err", err, 1'b0);
        tick();
        pend_q.delete();
        exp_q.delete();
        new_test();
        stray_n = 2;
        rst = 1'b1;
        repeat (4) tick();
        chk("F_err", err, 1'b1);
        chk("F_avail", available_read, 1'b0);
        chk("F_data", data_in, '0);
        cons_mode = 1; exp_addr = 64'h5000;
        start_xfer(64'h5000, 64'd3);
        wait_done(100);
        chk("F_pops", n_pop, 3);
        chk("F_err_sticky", err, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
